// File: rtl/lock_pkg.sv
// lock_pkg: key codes, FSM state encoding and sizing helpers shared by the lock sequencer
package lock_pkg;
  localparam int DIGITS = 6;
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_SET = 4'hC;
  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, OPEN, LOCKOUT, SET_ENTRY, SET_WRITE
  } state_t;
  function automatic int timer_width(int a, int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter; done is high once the count has reached zero
module lock_timer #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: keypad entry, compare, unlock, lockout and password-change sequencing
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int MAX_FAIL    = 3,
  parameter int OPEN_CYCLES = 1000,
  parameter int LOCK_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        cmp_match,
  output logic [23:0] entry,
  output logic        cmp_en,
  output logic        pw_we,
  output logic        unlock,
  output logic        alarm,
  output logic [1:0]  fail_cnt,
  output logic [2:0]  state
);
  localparam int TW = timer_width(OPEN_CYCLES, LOCK_CYCLES);
  state_t st, st_n;
  logic [23:0] entry_n;
  logic [2:0] cnt, cnt_n;
  logic [1:0] fail_n, fail_inc;
  logic t_load, t_done, is_digit, full;
  logic [TW-1:0] t_val;
  assign is_digit = key_code <= 4'd9;
  assign full = cnt == 3'(DIGITS);
  assign fail_inc = fail_cnt == 2'd3 ? fail_cnt : fail_cnt + 2'd1;
  lock_timer #(.W(TW)) u_timer (
    .clk(clk), .clr_n(clr_n), .load(t_load), .load_val(t_val), .done(t_done)
  );
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      st <= IDLE;
      entry <= '0;
      cnt <= '0;
      fail_cnt <= '0;
    end else begin
      st <= st_n;
      entry <= entry_n;
      cnt <= cnt_n;
      fail_cnt <= fail_n;
    end
  // cmp_en is issued with the ENTER strobe so cmp_match is ready during CHECK
  always_comb begin
    st_n = st;
    entry_n = entry;
    cnt_n = cnt;
    fail_n = fail_cnt;
    cmp_en = 1'b0;
    t_load = 1'b0;
    t_val = TW'(OPEN_CYCLES - 1);
    case (st)
      IDLE:
        if (key_valid && is_digit) begin
          entry_n = {20'd0, key_code};
          cnt_n = 3'd1;
          st_n = ENTRY;
        end
      ENTRY, SET_ENTRY:
        if (key_valid && is_digit && !full) begin
          entry_n = {entry[19:0], key_code};
          cnt_n = cnt + 3'd1;
        end else if (key_valid && key_code == KEY_CLEAR) begin
          entry_n = '0;
          cnt_n = '0;
          st_n = IDLE;
        end else if (key_valid && key_code == KEY_ENTER) begin
          if (full) begin
            cmp_en = st == ENTRY;
            st_n = st == ENTRY ? CHECK : SET_WRITE;
          end else if (st == ENTRY) begin
            entry_n = '0;
            cnt_n = '0;
          end
        end
      CHECK: begin
        entry_n = '0;
        cnt_n = '0;
        t_load = 1'b1;
        t_val = cmp_match ? TW'(OPEN_CYCLES - 1) : TW'(LOCK_CYCLES - 1);
        fail_n = cmp_match ? 2'd0 : fail_inc;
        st_n = cmp_match ? OPEN : (32'(fail_inc) == MAX_FAIL ? LOCKOUT : IDLE);
      end
      OPEN:
        if (key_valid && key_code == KEY_SET) begin
          entry_n = '0;
          cnt_n = '0;
          st_n = SET_ENTRY;
        end else if (t_done) st_n = IDLE;
      LOCKOUT:
        if (t_done) begin
          fail_n = '0;
          st_n = IDLE;
        end
      SET_WRITE: begin
        entry_n = '0;
        cnt_n = '0;
        st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end
  assign pw_we = st == SET_WRITE;
  assign unlock = st == OPEN;
  assign alarm = st == LOCKOUT;
  assign state = st;
endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed scenarios with a scoreboard of expected compares, writes and pulse lengths
module tb_lock_sequencer;
  import lock_pkg::*;
  localparam int OPEN_C = 12;
  localparam int LOCK_C = 30;
  logic clk = 1'b0, clr_n = 1'b0, key_valid = 1'b0, cmp_match;
  logic [3:0] key_code = 4'd0;
  logic [23:0] entry;
  logic cmp_en, pw_we, unlock, alarm;
  logic [1:0] fail_cnt;
  logic [2:0] state;
  logic [23:0] pw = 24'h123456;
  int checks = 0, errors = 0, u_run = 0, a_run = 0;
  int exp_open[$], exp_lock[$];
  logic [23:0] exp_cmp[$], exp_pw[$];
  always #5 clk = ~clk;
  assign cmp_match = entry == pw;
  always @(posedge clk) if (pw_we) pw <= entry;
  lock_sequencer #(.MAX_FAIL(3), .OPEN_CYCLES(OPEN_C), .LOCK_CYCLES(LOCK_C)) dut (
    .clk(clk), .clr_n(clr_n), .key_valid(key_valid), .key_code(key_code),
    .cmp_match(cmp_match), .entry(entry), .cmp_en(cmp_en), .pw_we(pw_we),
    .unlock(unlock), .alarm(alarm), .fail_cnt(fail_cnt), .state(state)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("exclusive_outputs", {30'd0, cmp_en && pw_we, unlock && alarm}, 32'd0);
    if (cmp_en) begin
      chk("cmp_en_expected", 32'(exp_cmp.size() > 0), 32'd1);
      if (exp_cmp.size() > 0) chk("cmp_entry", entry, exp_cmp.pop_front());
    end
    if (pw_we) begin
      chk("pw_we_expected", 32'(exp_pw.size() > 0), 32'd1);
      if (exp_pw.size() > 0) chk("pw_entry", entry, exp_pw.pop_front());
    end
    if (unlock) u_run++;
    else if (u_run > 0) begin
      chk("open_expected", 32'(exp_open.size() > 0), 32'd1);
      if (exp_open.size() > 0) chk("open_len", u_run, exp_open.pop_front());
      u_run = 0;
    end
    if (alarm) a_run++;
    else if (a_run > 0) begin
      chk("lock_expected", 32'(exp_lock.size() > 0), 32'd1);
      if (exp_lock.size() > 0) chk("lock_len", a_run, exp_lock.pop_front());
      a_run = 0;
    end
  end
  task automatic key(input logic [3:0] c);
    key_valid = 1'b1;
    key_code = c;
    @(posedge clk);
    #1 key_valid = 1'b0;
    key_code = 4'hF;
  endtask
  task automatic enter6(input logic [23:0] v);
    for (int i = 5; i >= 0; i--) key(v[i*4+:4]);
  endtask
  task automatic wait_state(input state_t s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    chk("wait_state", 32'(state), 32'(s));
  endtask
  task automatic idle_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(IDLE));
    chk({tag, "_entry"}, entry, 0);
    chk({tag, "_outs"}, {27'd0, cmp_en, pw_we, unlock, alarm, |fail_cnt}, 0);
  endtask
  initial begin
    #12 idle_outputs("reset");
    clr_n = 1'b1;
    @(posedge clk);
    #1 key(KEY_ENTER);
    key(KEY_SET);
    chk("idle_ignores", 32'(state), 32'(IDLE));
    enter6(24'h123456);
    chk("match_entry", entry, 24'h123456);
    exp_cmp.push_back(24'h123456);
    exp_open.push_back(OPEN_C);
    key(KEY_ENTER);
    chk("check_state", 32'(state), 32'(CHECK));
    wait_state(OPEN, 5);
    wait_state(IDLE, OPEN_C + 5);
    chk("match_fail_cnt", fail_cnt, 0);
    enter6(24'h123456);
    key(4'h9);
    chk("overflow_entry", entry, 24'h123456);
    key(KEY_CLEAR);
    chk("clear_entry", entry, 0);
    chk("clear_state", 32'(state), 32'(IDLE));
    for (int r = 1; r <= 3; r++) begin
      enter6(24'h111111);
      exp_cmp.push_back(24'h111111);
      if (r == 3) exp_lock.push_back(LOCK_C);
      key(KEY_ENTER);
      if (r < 3) begin
        wait_state(IDLE, 5);
        chk("fail_cnt_step", fail_cnt, r);
      end
      if (r == 1) begin
        key(4'h1);
        key(4'h2);
        key(4'h3);
        key(KEY_ENTER);
        chk("short_entry", entry, 0);
        chk("short_state", 32'(state), 32'(ENTRY));
        chk("short_fail_cnt", fail_cnt, 1);
        key(KEY_CLEAR);
      end
    end
    wait_state(LOCKOUT, 5);
    key(4'h1);
    key(KEY_ENTER);
    key(KEY_SET);
    chk("lock_state", 32'(state), 32'(LOCKOUT));
    chk("lock_entry", entry, 0);
    chk("lock_fail_cnt", fail_cnt, 3);
    wait_state(IDLE, LOCK_C + 10);
    chk("after_lock_fail_cnt", fail_cnt, 0);
    enter6(24'h123456);
    exp_cmp.push_back(24'h123456);
    exp_open.push_back(4);
    key(KEY_ENTER);
    wait_state(OPEN, 5);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    key(KEY_SET);
    chk("set_state", 32'(state), 32'(SET_ENTRY));
    chk("set_entry_clear", entry, 0);
    key(4'h9);
    key(4'h8);
    key(4'h7);
    key(KEY_ENTER);
    chk("set_short_state", 32'(state), 32'(SET_ENTRY));
    chk("set_short_entry", entry, 24'h000987);
    key(4'h6);
    key(4'h5);
    key(4'h4);
    exp_pw.push_back(24'h987654);
    key(KEY_ENTER);
    chk("set_write_state", 32'(state), 32'(SET_WRITE));
    @(posedge clk);
    #1 idle_outputs("after_write");
    enter6(24'h987654);
    exp_cmp.push_back(24'h987654);
    exp_open.push_back(OPEN_C);
    key(KEY_ENTER);
    wait_state(OPEN, 5);
    wait_state(IDLE, OPEN_C + 5);
    enter6(24'h987654);
    exp_cmp.push_back(24'h987654);
    key(KEY_ENTER);
    wait_state(OPEN, 5);
    clr_n = 1'b0;
    #1 idle_outputs("reset_open");
    #2 clr_n = 1'b1;
    @(posedge clk);
    #1 enter6(24'h987654);
    exp_cmp.push_back(24'h987654);
    exp_open.push_back(1);
    key(KEY_ENTER);
    wait_state(OPEN, 5);
    key(KEY_SET);
    enter6(24'h123456);
    clr_n = 1'b0;
    #1 idle_outputs("reset_set");
    #2 clr_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    idle_outputs("resume");
    chk("pending_cmp", exp_cmp.size(), 0);
    chk("pending_pw", exp_pw.size(), 0);
    chk("pending_open", exp_open.size(), 0);
    chk("pending_lock", exp_lock.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
